// File: rtl/riscv_timer_pkg.sv
// riscv_timer_pkg: shared constants and helpers for the memory-mapped machine timer.
//   - Bus widths, register offsets (decoded from addr[4:2]), CTRL bit positions,
//     prescaler width, bus FSM state type and a byte-lane merge helper.
package riscv_timer_pkg;

  localparam int unsigned RISCV_ADDR_WIDTH = 32;
  localparam int unsigned RISCV_WORD_WIDTH = 32;

  // Register offsets selected by addr[4:2]; 6 and 7 are unmapped.
  localparam logic [2:0] RegMtimeLo    = 3'd0;
  localparam logic [2:0] RegMtimeHi    = 3'd1;
  localparam logic [2:0] RegMtimecmpLo = 3'd2;
  localparam logic [2:0] RegMtimecmpHi = 3'd3;
  localparam logic [2:0] RegCtrl       = 3'd4;
  localparam logic [2:0] RegPrescale   = 3'd5;

  localparam int unsigned CtrlCntEnBit = 0;
  localparam int unsigned CtrlIrqEnBit = 1;

  localparam int unsigned PrescaleWidth = 16;

  typedef enum logic {StIdle, StResp} bus_state_e;

  // Replace the bytes of old_val whose write enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  we);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides enabled cycles into a one-cycle tick every div_i+1 enabled cycles.
// Only present in builds with RISCV_TIMER_PRESCALER_EN defined.
//   clk     - clock
//   rst     - asynchronous active-high reset
//   en_i    - count enable; cycles with en_i=0 are not counted
//   div_i   - divisor minus one (0 gives a tick every enabled cycle)
//   clr_i   - restart the division from zero
//   tick_o  - one-cycle tick
`ifdef RISCV_TIMER_PRESCALER_EN
module timer_prescaler #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [Width-1:0] div_i,
  input  logic             clr_i,
  output logic             tick_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/riscv_timer.sv
// riscv_timer: memory-mapped 64-bit machine timer (mtime / mtimecmp) with level interrupt.
// Optional feature macro: RISCV_TIMER_PRESCALER_EN (adds the PRESCALE register and divider;
// without it mtime ticks every enabled cycle and PRESCALE reads 0).
//   clk      - clock
//   rst      - asynchronous active-high reset
//   valid_i  - bus request, held until ready_o
//   ready_o  - one-cycle completion pulse, one cycle after the request is accepted
//   addr_i   - byte address, addr_i[4:2] selects the register
//   wdata_i  - write data
//   we_i     - byte write enables, all zero is a read
//   rdata_o  - read data, zero unless ready_o
//   irq_o    - registered timer interrupt: irq_en && mtime >= mtimecmp
module riscv_timer
  import riscv_timer_pkg::*;
#(
  parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [RISCV_ADDR_WIDTH-1:0] addr_i,
  input  logic [RISCV_WORD_WIDTH-1:0] wdata_i,
  input  logic [3:0]                  we_i,
  output logic [RISCV_WORD_WIDTH-1:0] rdata_o,
  output logic                        irq_o
);

  bus_state_e  state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  logic [2:0]  reg_sel;
  logic        accept;
  logic        wr_en;
  logic        tick;
  logic [31:0] rd_val;
  logic [31:0] prescale_rd;

  logic unused_addr;
  assign unused_addr = ^{addr_i[RISCV_ADDR_WIDTH-1:5], addr_i[1:0]};

  assign reg_sel = addr_i[4:2];
  assign accept  = (state_q == StIdle) && valid_i;
  assign wr_en   = accept && (we_i != 4'b0000);

`ifdef RISCV_TIMER_PRESCALER_EN
  logic [PrescaleWidth-1:0] prescale_q, prescale_d;
  logic                     prescale_wr;

  assign prescale_wr = wr_en && (reg_sel == RegPrescale);
  assign prescale_rd = {{(32-PrescaleWidth){1'b0}}, prescale_q};

  // Division restarts on any PRESCALE write and while counting is disabled.
  timer_prescaler #(
    .Width(PrescaleWidth)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en_i  (ctrl_q[CtrlCntEnBit]),
    .div_i (prescale_q),
    .clr_i (prescale_wr || !ctrl_q[CtrlCntEnBit]),
    .tick_o(tick)
  );

  always_comb begin
    prescale_d = prescale_q;
    if (prescale_wr) begin
      for (int b = 0; b < PrescaleWidth / 8; b++) begin
        if (we_i[b]) prescale_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prescale_q <= '0;
    else     prescale_q <= prescale_d;
  end
`else
  assign tick        = ctrl_q[CtrlCntEnBit];
  assign prescale_rd = '0;
`endif

  // Read mux over the pre-write register values.
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      RegMtimeLo:    rd_val = mtime_q[31:0];
      RegMtimeHi:    rd_val = mtime_q[63:32];
      RegMtimecmpLo: rd_val = mtimecmp_q[31:0];
      RegMtimecmpHi: rd_val = mtimecmp_q[63:32];
      RegCtrl:       rd_val = {30'b0, ctrl_q};
      RegPrescale:   rd_val = prescale_rd;
      default:       rd_val = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mtime_d    = mtime_q + {63'b0, tick};
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    rdata_d    = accept ? rd_val : '0;
    irq_d      = ctrl_q[CtrlIrqEnBit] && (mtime_q >= mtimecmp_q);

    unique case (state_q)
      StIdle:  if (valid_i) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A write to either mtime half replaces the tick: the other half keeps its pre-tick value.
    if (wr_en) begin
      case (reg_sel)
        RegMtimeLo:    mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata_i, we_i)};
        RegMtimeHi:    mtime_d = {merge_bytes(mtime_q[63:32], wdata_i, we_i), mtime_q[31:0]};
        RegMtimecmpLo: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wdata_i, we_i);
        RegMtimecmpHi: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata_i, we_i);
        RegCtrl:       if (we_i[0]) ctrl_d = wdata_i[1:0];
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mtime_q    <= '0;
      mtimecmp_q <= RESET_CMP;
      ctrl_q     <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign ready_o = (state_q == StResp);
  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule
